// File: rtl/amns_bram_sequencer_pkg.sv
// Shared definitions for the AMNS BRAM sequencer: FSM state type and the
// memory-map derivations reused by the top level and benches.
package amns_bram_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StKick,
        StRun,
        StRd,
        StOut
    } seq_state_e;

    // Operand image is A, B, M (N*S words each) followed by N words of M_prime_0.
    function automatic int unsigned calc_load_words(input int unsigned n, input int unsigned s);
        return 3 * n * s + n;
    endfunction

    function automatic int unsigned calc_res_base(input int unsigned n, input int unsigned s);
        return 3 * n * s + n;
    endfunction

    function automatic int unsigned calc_res_words(input int unsigned n, input int unsigned s);
        return n * s;
    endfunction

    function automatic int unsigned calc_addr_w(input int unsigned n, input int unsigned s);
        return $clog2(4 * n * s + n) + 1;
    endfunction

endpackage

// File: rtl/amns_bram_mux.sv
// Register-free BRAM port multiplexer: the core owns the port while
// sel_core is high, otherwise the sequencer drives it.
module amns_bram_mux #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                  sel_core,
    input  logic                  seq_we,
    input  logic                  seq_en,
    input  logic [ADDR_W-1:0]     seq_addr,
    input  logic [WORD_WIDTH-1:0] seq_din,
    input  logic                  core_we,
    input  logic                  core_en,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [WORD_WIDTH-1:0] core_din,
    output logic                  bram_we,
    output logic                  bram_en,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [WORD_WIDTH-1:0] bram_din
);

    always_comb begin
        if (sel_core) begin
            bram_we   = core_we;
            bram_en   = core_en;
            bram_addr = core_addr;
            bram_din  = core_din;
        end else begin
            bram_we   = seq_we;
            bram_en   = seq_en;
            bram_addr = seq_addr;
            bram_din  = seq_din;
        end
    end

endmodule

// File: rtl/amns_bram_sequencer.sv
// Loads AMNS operands into BRAM, kicks the core, then streams the result
// words back out of BRAM to the host.
module amns_bram_sequencer
    import amns_bram_sequencer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned N          = 5,
    parameter int unsigned LAMBDA     = 2,
    parameter int unsigned S          = 4,
    localparam int unsigned ADDR_W    = calc_addr_w(N, S)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  core_start_o,
    input  logic                  core_done_i,
    input  logic                  core_bram_we_i,
    input  logic                  core_bram_en_i,
    input  logic [ADDR_W-1:0]     core_bram_addr_i,
    input  logic [WORD_WIDTH-1:0] core_bram_din_i,
    output logic [WORD_WIDTH-1:0] core_bram_dout_o,
    output logic                  bram_we_o,
    output logic                  bram_en_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    output logic [WORD_WIDTH-1:0] bram_din_o,
    input  logic [WORD_WIDTH-1:0] bram_dout_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned LOAD_WORDS = calc_load_words(N, S);
    localparam int unsigned RES_BASE   = calc_res_base(N, S);
    localparam int unsigned RES_WORDS  = calc_res_words(N, S);

    // LAMBDA is carried for the core's benefit; only sanity-checked here.
    if (LAMBDA == 0) begin : g_lambda_check
        $error("LAMBDA must be nonzero");
    end

    seq_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic                  have_q, have_d;
    logic [WORD_WIDTH-1:0] out_data_q;
    logic                  capture;

    logic                  sel_core;
    logic                  seq_we, seq_en;
    logic [ADDR_W-1:0]     seq_addr;
    logic [WORD_WIDTH-1:0] seq_din;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            have_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            have_q  <= have_d;
            if (capture) begin
                out_data_q <= bram_dout_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        have_d       = have_q;
        capture      = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        core_start_o = 1'b0;
        done_o       = 1'b0;
        sel_core     = 1'b0;
        seq_we       = 1'b0;
        seq_en       = 1'b0;
        seq_addr     = '0;
        seq_din      = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    seq_we   = 1'b1;
                    seq_en   = 1'b1;
                    seq_addr = cnt_q;
                    seq_din  = in_data_i;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(LOAD_WORDS - 1)) begin
                        state_d = StKick;
                    end
                end
            end
            StKick: begin
                core_start_o = 1'b1;
                state_d      = StRun;
            end
            StRun: begin
                sel_core = 1'b1;
                if (core_done_i) begin
                    state_d = StRd;
                    cnt_d   = '0;
                end
            end
            StRd: begin
                seq_en   = 1'b1;
                seq_addr = ADDR_W'(RES_BASE) + cnt_q;
                state_d  = StOut;
            end
            StOut: begin
                // First OUT cycle latches the BRAM read data; valid follows.
                out_valid_o = have_q;
                if (!have_q) begin
                    capture = 1'b1;
                    have_d  = 1'b1;
                end else if (out_ready_i) begin
                    have_d = 1'b0;
                    if (cnt_q == ADDR_W'(RES_WORDS - 1)) begin
                        done_o  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o           = (state_q != StIdle);
    assign out_data_o       = out_data_q;
    assign core_bram_dout_o = bram_dout_i;

    amns_bram_mux #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_mux (
        .sel_core  (sel_core),
        .seq_we    (seq_we),
        .seq_en    (seq_en),
        .seq_addr  (seq_addr),
        .seq_din   (seq_din),
        .core_we   (core_bram_we_i),
        .core_en   (core_bram_en_i),
        .core_addr (core_bram_addr_i),
        .core_din  (core_bram_din_i),
        .bram_we   (bram_we_o),
        .bram_en   (bram_en_o),
        .bram_addr (bram_addr_o),
        .bram_din  (bram_din_o)
    );

endmodule

// File: tb/tb_amns_bram_sequencer.sv
// Randomized bench for amns_bram_sequencer with a BRAM model, a core model
// and a word-level reference of the load/run/readout protocol.
module tb_amns_bram_sequencer;

    localparam int WW = 17;
    localparam int AW = 8;
    localparam int LW = 65;
    localparam int RB = 65;
    localparam int RW = 20;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [WW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [WW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          core_start_o;
    logic          core_done_i;
    logic          core_bram_we_i;
    logic          core_bram_en_i;
    logic [AW-1:0] core_bram_addr_i;
    logic [WW-1:0] core_bram_din_i;
    logic [WW-1:0] core_bram_dout_o;
    logic          bram_we_o;
    logic          bram_en_o;
    logic [AW-1:0] bram_addr_o;
    logic [WW-1:0] bram_din_o;
    logic [WW-1:0] bram_dout_i;
    logic          busy_o;
    logic          done_o;

    logic [WW-1:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int exp_writes = 0;

    always #5 clock_i = ~clock_i;

    amns_bram_sequencer dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .in_data_i        (in_data_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .out_data_o       (out_data_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .core_start_o     (core_start_o),
        .core_done_i      (core_done_i),
        .core_bram_we_i   (core_bram_we_i),
        .core_bram_en_i   (core_bram_en_i),
        .core_bram_addr_i (core_bram_addr_i),
        .core_bram_din_i  (core_bram_din_i),
        .core_bram_dout_o (core_bram_dout_o),
        .bram_we_o        (bram_we_o),
        .bram_en_o        (bram_en_o),
        .bram_addr_o      (bram_addr_o),
        .bram_din_o       (bram_din_o),
        .bram_dout_i      (bram_dout_i),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    // Physical BRAM: read-first, one-cycle read latency.
    always @(posedge clock_i) begin
        if (bram_en_o === 1'b1) begin
            if (bram_we_o === 1'b1) mem[bram_addr_o] <= bram_din_o;
            bram_dout_i <= mem[bram_addr_o];
        end
    end

    always @(negedge clock_i) begin
        if (bram_we_o === 1'b1 && bram_en_o === 1'b1) n_writes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive_junk(input bit on);
        core_bram_we_i   = on;
        core_bram_en_i   = on;
        core_bram_addr_i = on ? AW'($urandom_range(84, 0)) : '0;
        core_bram_din_i  = on ? WW'($urandom) : '0;
    endtask

    task automatic pulse_start(input bit with_done);
        start_i     = 1'b1;
        core_done_i = with_done;
        step();
        start_i     = 1'b0;
        core_done_i = 1'b0;
    endtask

    // Drives one accepted load word; in LOAD every valid word is written at once.
    task automatic load_word(input int idx, input logic [WW-1:0] w, input bit junk);
        in_valid_i = 1'b1;
        in_data_i  = w;
        drive_junk(junk);
        exp_writes++;
        @(negedge clock_i);
        check("load_we", {30'd0, bram_we_o, bram_en_o}, 32'd3);
        check("load_addr", 32'(bram_addr_o), 32'(idx));
        check("load_din", 32'(bram_din_o), 32'(w));
        step();
    endtask

    task automatic gap_cycle(input bit junk);
        in_valid_i = 1'b0;
        drive_junk(junk);
        @(negedge clock_i);
        check("gap_no_write", 32'(bram_we_o), 32'd0);
        check("gap_ready", 32'(in_ready_o), 32'd1);
        step();
    endtask

    // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random. stall_mode: 0 none, 1 three, 2 random.
    task automatic run_txn(input int gap_mode, input int stall_mode, input bit junk,
                           input bit start_with_done);
        logic [WW-1:0] words [LW];
        logic [WW-1:0] res [RW];
        logic [WW-1:0] first;
        bit            seen;
        int            ng;
        int            nst;

        pulse_start(start_with_done);
        for (int i = 0; i < LW; i++) begin
            ng = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(2, 0)) : 0);
            for (int g = 0; g < ng; g++) gap_cycle(junk);
            words[i] = WW'($urandom);
            load_word(i, words[i], junk);
        end
        in_valid_i = 1'b0;
        drive_junk(1'b0);
        @(negedge clock_i);
        check("kick_start", 32'(core_start_o), 32'd1);
        check("kick_ready", 32'(in_ready_o), 32'd0);
        check("kick_no_write", 32'(bram_we_o), 32'd0);
        step();
        for (int i = 0; i < LW; i++) check("load_mem", 32'(mem[i]), 32'(words[i]));

        // Core model: writes the result image, with a stray host start mixed in.
        for (int j = 0; j < RW; j++) begin
            res[j]           = WW'($urandom);
            core_bram_we_i   = 1'b1;
            core_bram_en_i   = 1'b1;
            core_bram_addr_i = AW'(RB + j);
            core_bram_din_i  = res[j];
            start_i          = (j == 0);
            exp_writes++;
            @(negedge clock_i);
            if (j == 0) check("kick_once", 32'(core_start_o), 32'd0);
            if (j == 1) check("start_in_run", {30'd0, in_ready_o, busy_o}, 32'd1);
            check("run_pass_addr", 32'(bram_addr_o), 32'(RB + j));
            check("run_pass_din", 32'(bram_din_o), 32'(res[j]));
            step();
        end
        start_i = 1'b0;
        drive_junk(1'b0);
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;

        for (int k = 0; k < RW; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clock_i);
                if (out_valid_o === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                check("out_valid_timeout", 32'd0, 32'd1);
                return;
            end
            first = out_data_o;
            nst = (stall_mode == 1) ? 3 : (stall_mode == 2 ? int'($urandom_range(3, 0)) : 0);
            for (int s = 0; s < nst; s++) begin
                step();
                @(negedge clock_i);
                check("stall_data", 32'(out_data_o), 32'(first));
                check("stall_valid", 32'(out_valid_o), 32'd1);
            end
            step();
            out_ready_i = 1'b1;
            @(negedge clock_i);
            check("out_valid", 32'(out_valid_o), 32'd1);
            check("out_data", 32'(out_data_o), 32'(res[k]));
            check("done_pulse", 32'(done_o), (k == RW - 1) ? 32'd1 : 32'd0);
            step();
            out_ready_i = 1'b0;
        end
        @(negedge clock_i);
        check("end_busy", 32'(busy_o), 32'd0);
        check("end_done", 32'(done_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_ctrl"}, {25'd0, in_ready_o, out_valid_o, core_start_o, done_o,
                               bram_we_o, bram_en_o, 1'b0}, 32'd0);
        check({tag, "_out_data"}, 32'(out_data_o), 32'd0);
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        core_done_i = 1'b0;
        drive_junk(1'b0);
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check_all_zero("reset");
        step();
        reset_i = 1'b0;
        step();

        run_txn(0, 0, 1'b0, 1'b0);
        step();
        check("writes_t1", 32'(n_writes), 32'(exp_writes));
        run_txn(1, 1, 1'b1, 1'b1);
        step();
        check("writes_t2", 32'(n_writes), 32'(exp_writes));
        run_txn(2, 2, 1'b1, 1'b0);
        step();
        check("writes_t3", 32'(n_writes), 32'(exp_writes));

        // Abort after 30 words; the 31st word presented with reset must not land.
        pulse_start(1'b0);
        for (int i = 0; i < 30; i++) load_word(i, WW'($urandom), 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = WW'($urandom);
        reset_i    = 1'b1;
        @(negedge clock_i);
        check_all_zero("abort");
        step();
        reset_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clock_i);
        check("abort_idle", 32'(busy_o), 32'd0);
        step();
        check("writes_abort", 32'(n_writes), 32'(exp_writes));

        run_txn(2, 2, 1'b0, 1'b0);
        step();
        check("writes_final", 32'(n_writes), 32'(exp_writes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/amns_bram_sequencer.md
AMNS_BRAM_SEQUENCER -- requirements
Module: amns_bram_sequencer

Interface
REQ-001 Parameters: WORD_WIDTH, default 17, DSP word width; N, default 5, coefficients per AMNS polynomial; LAMBDA, default 2, passed through only; S, default 4, words per coefficient.
REQ-002 The design SHALL derive: LOAD_WORDS = 3*N*S+N (65 at defaults); RES_BASE = 3*N*S+N; RES_WORDS = N*S (20); ADDR_W = $clog2(4*N*S+N)+1 (8).
REQ-003 clock_i  in  1  single clock; all logic on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  host request for one modular multiplication; sampled in IDLE only.
REQ-006 in_data_i / in_valid_i / in_ready_o  in/in/out  WORD_WIDTH/1/1  operand load stream: A, B, M, then M_prime_0, low word first.
REQ-007 out_data_o / out_valid_o / out_ready_i  out/out/in  WORD_WIDTH/1/1  result stream, low word first.
REQ-008 core_start_o  out  1  start pulse to the AMNS core.
REQ-009 core_done_i  in  1  AMNS core done.
REQ-010 core_bram_we_i, core_bram_en_i  in  1 each; core_bram_addr_i  in  ADDR_W; core_bram_din_i  in  WORD_WIDTH  core BRAM port.
REQ-011 core_bram_dout_o  out  WORD_WIDTH  bram_dout_i forwarded unchanged.
REQ-012 bram_we_o, bram_en_o  out  1 each; bram_addr_o  out  ADDR_W; bram_din_o  out  WORD_WIDTH  physical BRAM port, 1-cycle read latency.
REQ-013 bram_dout_i  in  WORD_WIDTH  BRAM read data.
REQ-014 busy_o, done_o  out  1 each  busy = state not IDLE; done = one-cycle pulse when the last result word is accepted.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, KICK, RUN, RD, OUT.
REQ-016 IDLE -> LOAD on start_i=1; the write counter clears to 0.
REQ-017 LOAD: in_ready_o=1; each in_valid_i&in_ready_o SHALL write in_data_i at address = counter (we=en=1) in the same cycle, then increment the counter; gaps in in_valid_i SHALL stall without writes.
REQ-018 The accepted word with counter = LOAD_WORDS-1 SHALL move the FSM to KICK; in_ready_o SHALL be 0 outside LOAD.
REQ-019 KICK: core_start_o=1 for exactly one cycle, then RUN.
REQ-020 RUN: the BRAM port SHALL be a combinational pass-through of the core_bram_* inputs; in every other state, core requests SHALL be ignored.
REQ-021 RUN -> RD on core_done_i=1; the read counter clears to 0.
REQ-022 RD: en=1, we=0, addr = RES_BASE + read counter; next state OUT.
REQ-023 OUT: out_data_o = registered bram_dout_i, out_valid_o=1 held stable until out_ready_i=1; on acceptance, increment and return to RD, or, if it was word RES_WORDS-1, pulse done_o and go to IDLE.
REQ-024 start_i outside IDLE SHALL be ignored; start_i and core_done_i asserted together in IDLE SHALL start a load only.
REQ-025 Counters SHALL be ADDR_W bits and SHALL not wrap within one transaction.

Reset
REQ-026 While reset_i=1: state=IDLE; counters=0; in_ready_o, out_valid_o, core_start_o, done_o, busy_o, bram_we_o, bram_en_o = 0; out_data_o = 0.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no further BRAM write; BRAM contents are not cleared.

Structure
REQ-028 A shared package SHALL hold the state enum and the LOAD_WORDS/RES_BASE/RES_WORDS/ADDR_W computation functions, for reuse by AMNS_top and benches.
REQ-029 One sub-module, amns_bram_mux, SHALL implement the registered-free port multiplexer between sequencer and core.

Verification
REQ-030 Defaults, start_i pulse, 65 back-to-back words -> writes at addresses 0..64 on 65 consecutive cycles, then core_start_o high for exactly one cycle.
REQ-031 in_valid_i low every other cycle -> exactly 65 writes, addresses gap-free, KICK after word 64.
REQ-032 Core model writes 20 words at 65..84, then core_done_i -> out_data_o emits those 20 words in order, then done_o pulses once.
REQ-033 out_ready_i low 3 cycles per word -> out_data_o stable while stalled; no word lost or duplicated.
REQ-034 reset_i asserted after 30 loaded words -> next cycle all outputs are 0 and state is IDLE; a new start_i reloads from address 0.
REQ-035 start_i pulsed during RUN, and core BRAM writes during LOAD -> no effect on the FSM or the BRAM.
